lcd_ctrl: RTL and testbench

Responder-side HD44780 character-LCD sequencer. It sits between the LSU's LCD write port and the DE2 LCD pins. After reset it runs the power-up/initialisation sequence on its own. Afterwards it accepts one byte write (command or character) per valid/ready handshake and generates the bus timing, so software no longer bit-bangs EN/RS/RW.

---
 rtl/lcd_ctrl_pkg.sv | 27 ++
 rtl/lcd_timer.sv | 27 ++
 rtl/lcd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 character-LCD sequencer.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_SETUP,
        S_ENHI,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam int LCD_INIT_LEN = 6;

    // Larger of two integers, used to size the shared phase timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; zero flags the last cycle of the current phase.
module lcd_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 sequencer: power-up init, then one byte per valid/ready handshake
// with EN/RS/DATA timing generated in hardware. All outputs are registered.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_blon,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)),
                                max2(T_CMD, T_CLR));
    localparam int TW = $clog2(T_MAX) + 1;

    // Each phase loads T-1 so that it lasts exactly T cycles.
    localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP - 1);
    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
    localparam logic [TW-1:0] LD_CMD   = TW'(T_CMD - 1);
    localparam logic [TW-1:0] LD_CLR   = TW'(T_CLR - 1);
    localparam logic [2:0]    IDX_LAST = 3'(LCD_INIT_LEN - 1);

    lcd_state_e      state_reg, state_next;
    logic            en_reg, en_next;
    logic            rs_reg, rs_next;
    logic [7:0]      data_reg, data_next;
    logic            rdy_reg, rdy_next;
    logic            done_reg, done_next;
    logic            on_reg, on_next;
    logic [2:0]      idx_reg, idx_next;
    logic            tmr_load;
    logic [TW-1:0]   tmr_value;
    logic            tmr_zero;
    logic            slow_cmd;

    // Initialisation command sequence.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return LCD_FUNC_SET;
            3'd3:             return LCD_DISP_ON;
            3'd4:             return LCD_CLEAR;
            3'd5:             return LCD_ENTRY;
            default:          return LCD_FUNC_SET;
        endcase
    endfunction

    lcd_timer #(.WIDTH(TW)) u_timer (
        .clk   (i_clk),
        .rst_n (i_reset),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // Clear and home need the long busy wait; everything else the short one.
    assign slow_cmd = !rs_reg && ((data_reg == LCD_CLEAR) || (data_reg == LCD_HOME));

    // State and output registers; reset drops EN immediately.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= S_PWRUP;
            en_reg    <= 1'b0;
            rs_reg    <= 1'b0;
            data_reg  <= 8'h00;
            rdy_reg   <= 1'b0;
            done_reg  <= 1'b0;
            on_reg    <= 1'b0;
            idx_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            en_reg    <= en_next;
            rs_reg    <= rs_next;
            data_reg  <= data_next;
            rdy_reg   <= rdy_next;
            done_reg  <= done_next;
            on_reg    <= on_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state and next-output logic; phase ends when the timer hits zero.
    always_comb begin
        state_next = state_reg;
        en_next    = en_reg;
        rs_next    = rs_reg;
        data_next  = data_reg;
        rdy_next   = rdy_reg;
        done_next  = done_reg;
        on_next    = on_reg;
        idx_next   = idx_reg;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        case (state_reg)
            S_PWRUP: begin
                if (!on_reg) begin
                    // First cycle out of reset: power the panel, start the wait.
                    on_next   = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = LD_PWRUP;
                end else if (tmr_zero) begin
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                rs_next    = 1'b0;
                data_next  = init_rom(idx_reg);
                tmr_load   = 1'b1;
                tmr_value  = LD_SETUP;
                state_next = S_SETUP;
            end
            S_SETUP: begin
                if (tmr_zero) begin
                    en_next    = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_EN;
                    state_next = S_ENHI;
                end
            end
            S_ENHI: begin
                if (tmr_zero) begin
                    en_next    = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_HOLD;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    tmr_load   = 1'b1;
                    tmr_value  = slow_cmd ? LD_CLR : LD_CMD;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tmr_zero) begin
                    if (!done_reg) begin
                        idx_next = idx_reg + 3'd1;
                        if (idx_reg == IDX_LAST) begin
                            done_next  = 1'b1;
                            rdy_next   = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_INIT;
                        end
                    end else begin
                        rdy_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (i_req_vld && rdy_reg) begin
                    rs_next    = i_req_rs;
                    data_next  = i_req_data;
                    rdy_next   = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_SETUP;
                    state_next = S_SETUP;
                end
            end
            default: begin
                state_next = S_PWRUP;
            end
        endcase
    end

    assign o_req_rdy   = rdy_reg;
    assign o_init_done = done_reg;
    assign o_lcd_on    = on_reg;
    assign o_lcd_blon  = on_reg;
    assign o_lcd_en    = en_reg;
    assign o_lcd_rs    = rs_reg;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus pushes expected EN pulses,
// a negedge monitor pops and checks byte, gap, width and bus stability.
module tb_lcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 10;
    localparam int T_CLR   = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vld = 1'b0;
    logic       rs_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       o_req_rdy, o_init_done, o_lcd_on, o_lcd_blon;
    logic       o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req_vld   (vld),
        .i_req_rs    (rs_in),
        .i_req_data  (data_in),
        .o_req_rdy   (o_req_rdy),
        .o_init_done (o_init_done),
        .o_lcd_on    (o_lcd_on),
        .o_lcd_blon  (o_lcd_blon),
        .o_lcd_en    (o_lcd_en),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_rw    (o_lcd_rw),
        .o_lcd_data  (o_lcd_data)
    );

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [15:0] min_gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor state
    logic       in_pulse = 1'b0;
    int         gap = 0;
    int         width = 0;
    int         hold_left = 0;
    logic       stable_ok = 1'b1;
    logic [8:0] latched = '0;
    logic [8:0] h1 = '0;
    logic [8:0] h2 = '0;
    logic [8:0] cur_bus;
    exp_t       e;

    task automatic push(input logic rs, input logic [7:0] data, input int min_gap);
        exp_t x;
        x.rs = rs;
        x.data = data;
        x.min_gap = 16'(min_gap);
        exp_q.push_back(x);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, T_PWRUP);
        push(1'b0, 8'h38, 12);
        push(1'b0, 8'h38, 12);
        push(1'b0, 8'h0C, 12);
        push(1'b0, 8'h01, 12);
        push(1'b0, 8'h06, T_CLR);
    endtask

    // Pop and check one expected pulse per EN rise; track width, gap, stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse  = 1'b0;
            gap       = 0;
            hold_left = 0;
            h1        = '0;
            h2        = '0;
        end else begin
            cur_bus = {o_lcd_rs, o_lcd_data};
            if (o_lcd_en && !in_pulse) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got rs=%0b data=%02h, required no pulse",
                             o_lcd_rs, o_lcd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_bus !== {e.rs, e.data}) begin
                        errors++;
                        $display("FAIL pulse_byte: got rs=%0b data=%02h, required rs=%0b data=%02h",
                                 o_lcd_rs, o_lcd_data, e.rs, e.data);
                    end
                    checks++;
                    if (gap < int'(e.min_gap)) begin
                        errors++;
                        $display("FAIL pulse_gap: got %0d idle cycles, required >= %0d",
                                 gap, e.min_gap);
                    end
                end
                checks++;
                if (h1 !== cur_bus || h2 !== cur_bus) begin
                    errors++;
                    $display("FAIL setup_stable: got %03h,%03h before EN, required %03h",
                             h2, h1, cur_bus);
                end
                checks++;
                if (o_lcd_rw !== 1'b0) begin
                    errors++;
                    $display("FAIL lcd_rw: got %0b, required 0", o_lcd_rw);
                end
                in_pulse  = 1'b1;
                width     = 1;
                latched   = cur_bus;
                stable_ok = 1'b1;
            end else if (o_lcd_en) begin
                width++;
                if (cur_bus !== latched) stable_ok = 1'b0;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                gap = 1;
                if (cur_bus !== latched) stable_ok = 1'b0;
                hold_left = T_HOLD - 1;
                checks++;
                if (width != T_EN) begin
                    errors++;
                    $display("FAIL en_width: got %0d cycles, required %0d", width, T_EN);
                end
            end else begin
                gap++;
                if (hold_left > 0) begin
                    hold_left--;
                    if (cur_bus !== latched) stable_ok = 1'b0;
                    if (hold_left == 0) begin
                        checks++;
                        if (!stable_ok) begin
                            errors++;
                            $display("FAIL bus_stable: rs/data changed during EN/hold, required %03h",
                                     latched);
                        end
                    end
                end
            end
            h2 = h1;
            h1 = cur_bus;
        end
    end

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic wait_rdy(input string name, output int n);
        n = 0;
        while (o_req_rdy !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (o_req_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got rdy=%0b after %0d cycles, required 1", name, o_req_rdy, n);
        end
    endtask

    // Assert reset between edges, check outputs, release and queue the init bytes.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_on, o_lcd_blon, o_lcd_rw,
             o_req_rdy, o_init_done} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%0b rs=%0b data=%02h on=%0b blon=%0b rw=%0b rdy=%0b done=%0b, required all 0",
                     o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_on, o_lcd_blon, o_lcd_rw,
                     o_req_rdy, o_init_done);
        end
        exp_q.delete();
        push_init();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_bit("lcd_on_after_release", o_lcd_on, 1'b1);
        check_bit("lcd_blon_after_release", o_lcd_blon, 1'b1);
        check_bit("init_done_after_release", o_init_done, 1'b0);
        check_bit("rdy_after_release", o_req_rdy, 1'b0);
    endtask

    // One accepted write, then check busy flag and exact occupancy.
    task automatic send(input logic rs, input logic [7:0] data, input int min_gap,
                        input int exp_lat);
        int n;
        push(rs, data, min_gap);
        vld = 1'b1;
        rs_in = rs;
        data_in = data;
        @(posedge clk);
        #1;
        vld = 1'b0;
        check_bit("rdy_drop", o_req_rdy, 1'b0);
        wait_rdy("send", n);
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL latency_%02h: got %0d cycles, required %0d", data, n, exp_lat);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pulses outstanding, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        int n;
        #1;
        // Power-up and init sequence
        apply_reset();
        wait_rdy("init", n);
        check_bit("init_done", o_init_done, 1'b1);
        check_queue_empty("init_pulses");

        // Single writes with short and long busy waits
        send(1'b1, 8'h41, 12, T_SETUP + T_EN + T_HOLD + T_CMD);
        send(1'b0, 8'h01, 12, T_SETUP + T_EN + T_HOLD + T_CLR);
        send(1'b0, 8'h02, T_CLR, T_SETUP + T_EN + T_HOLD + T_CLR);
        send(1'b0, 8'h80, T_CLR, T_SETUP + T_EN + T_HOLD + T_CMD);
        send(1'b1, 8'h01, 12, T_SETUP + T_EN + T_HOLD + T_CMD);
        check_queue_empty("single_writes");

        // Valid held through init: nothing taken until init completes
        vld = 1'b1;
        rs_in = 1'b1;
        data_in = 8'h48;
        apply_reset();
        push(1'b1, 8'h48, 12);
        push(1'b1, 8'h49, 12);
        wait_rdy("held_init", n);
        check_bit("held_done_at_rdy", o_init_done, 1'b1);
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL held_no_early_accept: got %0d pulses outstanding, required 2", exp_q.size());
        end
        @(posedge clk);
        #1;
        data_in = 8'h49;
        check_bit("held_rdy_drop", o_req_rdy, 1'b0);
        wait_rdy("held_first", n);
        @(posedge clk);
        #1;
        vld = 1'b0;
        wait_rdy("held_second", n);
        check_queue_empty("held_pulses");

        // Reset asserted while EN is high
        push(1'b1, 8'h5A, 12);
        vld = 1'b1;
        rs_in = 1'b1;
        data_in = 8'h5A;
        @(posedge clk);
        #1;
        vld = 1'b0;
        n = 0;
        while (o_lcd_en !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_bit("en_seen_before_reset", o_lcd_en, 1'b1);
        @(negedge clk);
        #2;
        check_queue_empty("mid_pulse_popped");
        apply_reset();
        repeat (60) @(posedge clk);
        #1;
        check_bit("done_low_mid_reinit", o_init_done, 1'b0);
        wait_rdy("reinit", n);
        check_bit("reinit_done", o_init_done, 1'b1);
        check_queue_empty("reinit_pulses");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
